// File: rtl/alu_mc_pkg.sv
// Shared opcode map, FSM state type and flag helper for the multi-cycle ALU.
package alu_pkg;

   localparam int OPW = 5;

   localparam logic [OPW-1:0] OP_PASSD = 5'b00000;
   localparam logic [OPW-1:0] OP_ADD   = 5'b00001;
   localparam logic [OPW-1:0] OP_ADC   = 5'b00010;
   localparam logic [OPW-1:0] OP_SUB   = 5'b00011;
   localparam logic [OPW-1:0] OP_AND   = 5'b00100;
   localparam logic [OPW-1:0] OP_OR    = 5'b00101;
   localparam logic [OPW-1:0] OP_XOR   = 5'b00110;
   localparam logic [OPW-1:0] OP_INC   = 5'b00111;
   localparam logic [OPW-1:0] OP_DEC   = 5'b01000;
   localparam logic [OPW-1:0] OP_COM   = 5'b01001;
   localparam logic [OPW-1:0] OP_LSR   = 5'b01010;
   localparam logic [OPW-1:0] OP_CP    = 5'b01011;
   localparam logic [OPW-1:0] OP_ROR   = 5'b01100;
   localparam logic [OPW-1:0] OP_NEG   = 5'b01101;
   localparam logic [OPW-1:0] OP_ASR   = 5'b01110;
   localparam logic [OPW-1:0] OP_SWAP  = 5'b01111;
   localparam logic [OPW-1:0] OP_MUL   = 5'b10000;
   localparam logic [OPW-1:0] OP_DIV   = 5'b10001;
   localparam logic [OPW-1:0] OP_PASSA = 5'b11110;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   // Signed overflow of r = a + b, given the sign bits (pass ~b for subtraction).
   function automatic logic add_ovf(input logic a, input logic b, input logic r);
      return (a == b) && (r != a);
   endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative W-cycle engine: unsigned shift-add multiply and restoring divide.
// The accept edge only loads operands; W further edges each do one step.
// hi/lo present the next-state values so the caller can capture them on the
// same edge as the final iteration (done is high during that last cycle).
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         is_div,
   input  logic [W-1:0] op_a,      // multiplicand / dividend
   input  logic [W-1:0] op_b,      // multiplier / divisor
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         div_zero
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_e        state;
   logic [CW-1:0] cnt;
   logic          div_r;
   logic [W-1:0]  acc;    // partial product high half / partial remainder
   logic [W-1:0]  qr;     // multiplier shifting out / quotient shifting in
   logic [W-1:0]  m;      // multiplicand / divisor
   logic [W:0]    sum;
   logic [W:0]    trial;
   logic [W-1:0]  acc_nx;
   logic [W-1:0]  qr_nx;

   // One iteration step; a zero divisor always "fits" so quotient fills with ones
   always_comb begin
      sum   = {1'b0, acc} + {1'b0, m};
      trial = {acc, qr[W-1]} - {1'b0, m};
      if (div_r) begin
         if (!trial[W] || div_zero) begin
            acc_nx = trial[W-1:0];
            qr_nx  = {qr[W-2:0], 1'b1};
         end else begin
            acc_nx = {acc[W-2:0], qr[W-1]};
            qr_nx  = {qr[W-2:0], 1'b0};
         end
      end else if (qr[0]) begin
         acc_nx = sum[W:1];
         qr_nx  = {sum[0], qr[W-1:1]};
      end else begin
         acc_nx = {1'b0, acc[W-1:1]};
         qr_nx  = {acc[0], qr[W-1:1]};
      end
   end

   // IDLE/RUN sequencing and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         div_r    <= 1'b0;
         div_zero <= 1'b0;
         acc      <= '0;
         qr       <= '0;
         m        <= '0;
      end else if (state == IDLE) begin
         if (start) begin
            state    <= RUN;
            cnt      <= CW'(W - 1);
            div_r    <= is_div;
            div_zero <= is_div && (op_b == '0);
            acc      <= '0;
            qr       <= is_div ? op_a : op_b;
            m        <= is_div ? op_b : op_a;
         end
      end else begin
         acc <= acc_nx;
         qr  <= qr_nx;
         cnt <= cnt - CNT_ONE;
         if (cnt == '0) state <= IDLE;
      end
   end

   assign busy = (state == RUN);
   assign done = busy && (cnt == '0);
   assign hi   = acc_nx;
   assign lo   = qr_nx;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: single-cycle ops, flag registers and result mux;
// MUL/DIV are delegated to the iterative engine.
module alu_mc
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en_alu,
   input  logic [OPW-1:0] aluop,
   input  logic [W-1:0]   RD,
   input  logic [W-1:0]   RA,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   out,
   output logic [W-1:0]   hi,
   output logic           cy,
   output logic           zy,
   output logic           nf,
   output logic           vf
);

   localparam logic [W-1:0] ONE = W'(1);

   logic         is_md;
   logic         accept;
   logic         eng_done;
   logic         eng_dz;
   logic [W-1:0] eng_hi;
   logic [W-1:0] eng_lo;
   logic         div_op_r;
   logic [W-1:0] s_out;
   logic         s_cy;
   logic         s_vf;
   logic [W:0]   sum;

   assign is_md  = (aluop == OP_MUL) || (aluop == OP_DIV);
   assign accept = en_alu && !busy;

   alu_muldiv_iter #(.W(W)) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .start    (accept && is_md),
      .is_div   (aluop == OP_DIV),
      .op_a     (RD),
      .op_b     (RA),
      .busy     (busy),
      .done     (eng_done),
      .hi       (eng_hi),
      .lo       (eng_lo),
      .div_zero (eng_dz)
   );

   // Single-cycle result, carry and overflow for the current opcode
   always_comb begin
      s_out = '0;
      s_cy  = 1'b0;
      s_vf  = 1'b0;
      sum   = '0;
      case (aluop)
         OP_PASSD: s_out = RD;
         OP_ADD: begin
            sum   = {1'b0, RD} + {1'b0, RA};
            s_out = sum[W-1:0];
            s_cy  = sum[W];
            s_vf  = add_ovf(RD[W-1], RA[W-1], s_out[W-1]);
         end
         OP_ADC: begin
            sum   = {1'b0, RD} + {1'b0, RA} + {{W{1'b0}}, cy};
            s_out = sum[W-1:0];
            s_cy  = sum[W];
            s_vf  = add_ovf(RD[W-1], RA[W-1], s_out[W-1]);
         end
         OP_SUB: begin
            s_out = RD - RA;
            s_cy  = (RD < RA);
            s_vf  = add_ovf(RD[W-1], ~RA[W-1], s_out[W-1]);
         end
         OP_AND: s_out = RD & RA;
         OP_OR:  s_out = RD | RA;
         OP_XOR: s_out = RD ^ RA;
         OP_INC: begin
            sum   = {1'b0, RD} + {1'b0, ONE};
            s_out = sum[W-1:0];
            s_cy  = sum[W];
            s_vf  = !RD[W-1] && s_out[W-1];
         end
         OP_DEC: begin
            s_out = RD - ONE;
            s_cy  = (RD == '0);
            s_vf  = RD[W-1] && !s_out[W-1];
         end
         OP_COM: s_out = ~RD;
         OP_LSR: begin
            s_out = {1'b0, RD[W-1:1]};
            s_cy  = RD[0];
         end
         OP_CP: begin
            s_out = RD;
            s_cy  = (RD != RA);
         end
         OP_ROR: begin
            s_out = {cy, RD[W-1:1]};
            s_cy  = RD[0];
         end
         OP_NEG: begin
            s_out = '0 - RD;
            s_cy  = (RD != '0);
            s_vf  = RD[W-1] && s_out[W-1];
         end
         OP_ASR: begin
            s_out = {RD[W-1], RD[W-1:1]};
            s_cy  = cy;
         end
         OP_SWAP:  s_out = {RD[W/2-1:0], RD[W-1:W/2]};
         OP_PASSA: s_out = RA;
         default: ;
      endcase
   end

   // Result/flag registers: update only on a single-cycle accept or engine finish
   always_ff @(posedge clk) begin
      if (rst) begin
         out      <= '0;
         hi       <= '0;
         cy       <= 1'b0;
         zy       <= 1'b1;
         nf       <= 1'b0;
         vf       <= 1'b0;
         done     <= 1'b0;
         div_op_r <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept && !is_md) begin
            out  <= s_out;
            hi   <= '0;
            cy   <= s_cy;
            zy   <= (s_out == '0);
            nf   <= s_out[W-1];
            vf   <= s_vf;
            done <= 1'b1;
         end else if (eng_done) begin
            out  <= eng_lo;
            hi   <= eng_hi;
            cy   <= div_op_r ? eng_dz : (eng_hi != '0);
            zy   <= (eng_lo == '0);
            nf   <= eng_lo[W-1];
            vf   <= 1'b0;
            done <= 1'b1;
         end
         if (accept && is_md) div_op_r <= (aluop == OP_DIV);
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed scoreboard bench for alu_mc at W=8 and W=16.
module tb_alu_mc;
   import alu_pkg::*;

   typedef struct packed {
      logic [15:0] out;
      logic [15:0] hi;
      logic        cy;
      logic        zy;
      logic        nf;
      logic        vf;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a;
   logic [4:0] op_a;
   logic [7:0] rd_a, ra_a;
   logic       a_busy, a_done, a_cy, a_zy, a_nf, a_vf;
   logic [7:0] a_out, a_hi;

   logic        rst_b, en_b;
   logic [4:0]  op_b;
   logic [15:0] rd_b, ra_b;
   logic        b_busy, b_done, b_cy, b_zy, b_nf, b_vf;
   logic [15:0] b_out, b_hi;

   res_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   a_ops = 0;
   int   a_dones = 0;

   alu_mc #(.W(8)) dut_a (
      .clk(clk), .rst(rst_a), .en_alu(en_a), .aluop(op_a), .RD(rd_a), .RA(ra_a),
      .busy(a_busy), .done(a_done), .out(a_out), .hi(a_hi),
      .cy(a_cy), .zy(a_zy), .nf(a_nf), .vf(a_vf)
   );

   alu_mc #(.W(16)) dut_b (
      .clk(clk), .rst(rst_b), .en_alu(en_b), .aluop(op_b), .RD(rd_b), .RA(ra_b),
      .busy(b_busy), .done(b_done), .out(b_out), .hi(b_hi),
      .cy(b_cy), .zy(b_zy), .nf(b_nf), .vf(b_vf)
   );

   always @(negedge clk) if (a_done === 1'b1) a_dones++;

   function automatic res_t mk(input logic [15:0] o, input logic [15:0] h,
                               input logic c, input logic z, input logic n, input logic v);
      res_t r;
      r.out = o; r.hi = h; r.cy = c; r.zy = z; r.nf = n; r.vf = v;
      return r;
   endfunction

   function automatic res_t cur_res(input int sel);
      if (sel == 0) return mk({8'h00, a_out}, {8'h00, a_hi}, a_cy, a_zy, a_nf, a_vf);
      return mk(b_out, b_hi, b_cy, b_zy, b_nf, b_vf);
   endfunction

   function automatic logic cur_done(input int sel);
      return (sel == 0) ? a_done : b_done;
   endfunction

   function automatic logic cur_busy(input int sel);
      return (sel == 0) ? a_busy : b_busy;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive one request (entered just after a rising edge), wait for done,
   // then compare against the scoreboard entry and the expected latency.
   task automatic run_op(input int sel, input string tag, input logic [4:0] op,
                         input logic [15:0] rd, input logic [15:0] ra,
                         input res_t exp, input int exp_lat, input bit poke);
      int   lat;
      bit   seen;
      res_t want;
      if (sel == 0) begin
         en_a = 1'b1; op_a = op; rd_a = rd[7:0]; ra_a = ra[7:0]; a_ops++;
      end else begin
         en_b = 1'b1; op_b = op; rd_b = rd; ra_b = ra;
      end
      sb_q.push_back(exp);
      @(posedge clk); #1;
      en_a = 1'b0; en_b = 1'b0;
      lat = 0; seen = 0;
      while (lat <= 40) begin
         @(negedge clk);
         if (cur_done(sel) === 1'b1) begin seen = 1; break; end
         if (lat == 0 && exp_lat > 0) check({tag, "_busy"}, 64'(cur_busy(sel)), 64'd1);
         if (poke && lat == 1) begin en_a = 1'b1; op_a = OP_ADD; rd_a = 8'h01; ra_a = 8'h01; end
         if (poke && lat == 2) en_a = 1'b0;
         lat++;
      end
      want = sb_q.pop_front();
      if (!seen) begin
         check({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         check({tag, "_res"}, 64'(cur_res(sel)), 64'(want));
         check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      end
      @(negedge clk);
      check({tag, "_pulse"}, 64'(cur_done(sel)), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_a = 1'b1; en_a = 1'b0; op_a = '0; rd_a = '0; ra_a = '0;
      rst_b = 1'b1; en_b = 1'b0; op_b = '0; rd_b = '0; ra_b = '0;
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("reset_a", {a_out, a_hi, a_cy, a_zy, a_nf, a_vf, a_busy, a_done},
            {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;

      // carry chain and overflow
      run_op(0, "add_ff_01", OP_ADD, 16'hFF, 16'h01, mk(16'h00, 0, 1, 1, 0, 0), 0, 0);
      run_op(0, "adc_10_20", OP_ADC, 16'h10, 16'h20, mk(16'h31, 0, 0, 0, 0, 0), 0, 0);
      run_op(0, "add_7f_01", OP_ADD, 16'h7F, 16'h01, mk(16'h80, 0, 0, 0, 1, 1), 0, 0);
      run_op(0, "sub_05_07", OP_SUB, 16'h05, 16'h07, mk(16'hFE, 0, 1, 0, 1, 0), 0, 0);

      // multi-cycle ops; 600 = 0x258, 100 = 7*14 + 2
      run_op(0, "mul_200_3", OP_MUL, 16'hC8, 16'h03, mk(16'h58, 16'h02, 1, 0, 0, 0), 8, 1);
      run_op(0, "div_100_7", OP_DIV, 16'h64, 16'h07, mk(16'h0E, 16'h02, 0, 0, 0, 0), 8, 0);
      run_op(0, "div_by_0",  OP_DIV, 16'h55, 16'h00, mk(16'hFF, 16'h55, 1, 0, 1, 0), 8, 0);

      // single-cycle shifts and logic, cy starts at 1 here
      run_op(0, "asr_80",    OP_ASR,   16'h80, 16'h00, mk(16'hC0, 0, 1, 0, 1, 0), 0, 0);
      run_op(0, "ror_02",    OP_ROR,   16'h02, 16'h00, mk(16'h81, 0, 0, 0, 1, 0), 0, 0);
      run_op(0, "lsr_03",    OP_LSR,   16'h03, 16'h00, mk(16'h01, 0, 1, 0, 0, 0), 0, 0);
      run_op(0, "cp_eq",     OP_CP,    16'h33, 16'h33, mk(16'h33, 0, 0, 0, 0, 0), 0, 0);
      run_op(0, "inc_7f",    OP_INC,   16'h7F, 16'h00, mk(16'h80, 0, 0, 0, 1, 1), 0, 0);
      run_op(0, "inc_ff",    OP_INC,   16'hFF, 16'h00, mk(16'h00, 0, 1, 1, 0, 0), 0, 0);
      run_op(0, "com_0f",    OP_COM,   16'h0F, 16'h00, mk(16'hF0, 0, 0, 0, 1, 0), 0, 0);
      run_op(0, "and",       OP_AND,   16'hF0, 16'h3C, mk(16'h30, 0, 0, 0, 0, 0), 0, 0);
      run_op(0, "xor_self",  OP_XOR,   16'hAA, 16'hAA, mk(16'h00, 0, 0, 1, 0, 0), 0, 0);
      run_op(0, "pass_ra",   OP_PASSA, 16'h11, 16'h5A, mk(16'h5A, 0, 0, 0, 0, 0), 0, 0);
      run_op(0, "bad_op",    5'b10101, 16'hFF, 16'hFF, mk(16'h00, 0, 0, 1, 0, 0), 0, 0);
      run_op(0, "swap_3c",   OP_SWAP,  16'h3C, 16'h00, mk(16'hC3, 0, 0, 0, 1, 0), 0, 0);

      // reset four cycles into a MUL aborts it without a done
      en_a = 1'b1; op_a = OP_MUL; rd_a = 8'hC8; ra_a = 8'h03;
      @(posedge clk); #1 en_a = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_a = 1'b1;
      @(posedge clk); #1 rst_a = 1'b0;
      @(negedge clk);
      check("abort_state", {a_out, a_hi, a_cy, a_zy, a_nf, a_vf, a_busy, a_done},
            {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      begin
         int stray;
         stray = 0;
         repeat (10) begin
            @(negedge clk);
            if (a_done !== 1'b0) stray++;
         end
         check("abort_no_done", 64'(stray), 64'd0);
      end
      @(posedge clk); #1;
      run_op(0, "add_after_rst", OP_ADD, 16'h01, 16'h01, mk(16'h02, 0, 0, 0, 0, 0), 0, 0);

      // W=16 instance
      run_op(1, "mul16_ffff", OP_MUL, 16'hFFFF, 16'hFFFF, mk(16'h0001, 16'hFFFE, 1, 0, 0, 0), 16, 0);
      run_op(1, "swap16", OP_SWAP, 16'h12AB, 16'h0000, mk(16'hAB12, 0, 0, 0, 1, 0), 0, 0);

      // reset and request in the same cycle: reset wins
      rst_b = 1'b1; en_b = 1'b1; op_b = OP_ADD; rd_b = 16'h0001; ra_b = 16'h0001;
      @(posedge clk); #1 rst_b = 1'b0; en_b = 1'b0;
      @(negedge clk);
      check("rst_wins", {b_out, b_zy, b_done, b_busy}, {16'h0000, 1'b1, 1'b0, 1'b0});

      @(negedge clk);
      check("done_count_a", 64'(a_dones), 64'(a_ops));
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
